// File: rtl/reg_seq_ctrl_if.sv
// reg_seq_ctrl_if -- bus bundle between the instruction sequencer, its
// instruction source, the register file and the ALU.
//
// Signal groups:
//   instruction : instr_valid, instr_ready, rs1, rs2, rd, wb_req, flag_req
//   reg file    : get_reg_en, reg1, reg2, reg_write_back, reg_write_code,
//                 data_in, flag_update, SREG_write
//   ALU         : alu_start, alu_done, alu_result, alu_flags
//
// Modports: master = sequencer side, slave = environment side.
interface reg_seq_ctrl_if #(
    parameter int WORD = 16
);
    logic            instr_valid;
    logic            instr_ready;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [2:0]      rd;
    logic            wb_req;
    logic            flag_req;

    logic            get_reg_en;
    logic [2:0]      reg1;
    logic [2:0]      reg2;
    logic            reg_write_back;
    logic [2:0]      reg_write_code;
    logic [WORD-1:0] data_in;
    logic            flag_update;
    logic [WORD-1:0] SREG_write;

    logic            alu_start;
    logic            alu_done;
    logic [WORD-1:0] alu_result;
    logic [WORD-1:0] alu_flags;

    modport master (
        input  instr_valid, rs1, rs2, rd, wb_req, flag_req,
        input  alu_done, alu_result, alu_flags,
        output instr_ready, get_reg_en, reg1, reg2,
        output reg_write_back, reg_write_code, data_in, flag_update, SREG_write,
        output alu_start
    );

    modport slave (
        output instr_valid, rs1, rs2, rd, wb_req, flag_req,
        output alu_done, alu_result, alu_flags,
        input  instr_ready, get_reg_en, reg1, reg2,
        input  reg_write_back, reg_write_code, data_in, flag_update, SREG_write,
        input  alu_start
    );
endinterface

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl -- sequences one instruction at a time through register read,
// ALU execution and register/status write-back. Every output is registered.
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : asynchronous active-high reset
//   bus           : reg_seq_ctrl_if.master (instruction, reg file, ALU)
//   busy_o        : high in every state except IDLE
//   timeout_err_o : sticky, set when the ALU does not answer within TIMEOUT cycles
//   instr_count_o : completed instructions, wraps at 16 bits
//
// Build option: REG_SEQ_BACK2BACK_EN -- accept the next instruction during WB
// and go straight to READ.
//
// state | meaning
// IDLE  | ready for an instruction
// READ  | one-cycle register-file read of rs1/rs2
// EXEC  | ALU running, waiting for alu_done or timeout
// WB    | one-cycle register and/or status write
module reg_seq_ctrl #(
    parameter int WORD     = 16,
    parameter int SREG_IDX = 7,
    parameter int TIMEOUT  = 255
) (
    input  logic           clk,
    input  logic           rst,
    reg_seq_ctrl_if.master bus,
    output logic           busy_o,
    output logic           timeout_err_o,
    output logic [15:0]    instr_count_o
);
    // Timer holds at most TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t state_q, state_d;

    logic [2:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic            wb_req_q, wb_req_d, flag_req_q, flag_req_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            terr_q, terr_d;
    logic            busy_q, busy_d;
    logic            rdy_q, rdy_d;
    logic            get_en_q, get_en_d;
    logic [2:0]      reg1_q, reg1_d, reg2_q, reg2_d;
    logic            alu_start_q, alu_start_d;
    logic            wb_q, wb_d, fu_q, fu_d;
    logic [2:0]      code_q, code_d;
    logic [WORD-1:0] data_q, data_d, sreg_q, sreg_d;
    logic            accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wb_req_q    <= 1'b0;
            flag_req_q  <= 1'b0;
            tmr_q       <= '0;
            cnt_q       <= '0;
            terr_q      <= 1'b0;
            busy_q      <= 1'b0;
            rdy_q       <= 1'b1;
            get_en_q    <= 1'b0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            alu_start_q <= 1'b0;
            wb_q        <= 1'b0;
            fu_q        <= 1'b0;
            code_q      <= '0;
            data_q      <= '0;
            sreg_q      <= '0;
        end else begin
            state_q     <= state_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            wb_req_q    <= wb_req_d;
            flag_req_q  <= flag_req_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            terr_q      <= terr_d;
            busy_q      <= busy_d;
            rdy_q       <= rdy_d;
            get_en_q    <= get_en_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            alu_start_q <= alu_start_d;
            wb_q        <= wb_d;
            fu_q        <= fu_d;
            code_q      <= code_d;
            data_q      <= data_d;
            sreg_q      <= sreg_d;
        end
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    always_comb begin
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        wb_req_d    = wb_req_q;
        flag_req_d  = flag_req_q;
        tmr_d       = tmr_q;
        cnt_d       = cnt_q;
        terr_d      = terr_q;
        reg1_d      = reg1_q;
        reg2_d      = reg2_q;
        code_d      = code_q;
        data_d      = data_q;
        sreg_d      = sreg_q;
        get_en_d    = 1'b0;
        alu_start_d = 1'b0;
        wb_d        = 1'b0;
        fu_d        = 1'b0;
        accept      = 1'b0;

        case (state_q)
            S_IDLE: begin
                accept = bus.instr_valid && rdy_q;
            end
            S_READ: begin
                state_d     = S_EXEC;
                alu_start_d = 1'b1;
                tmr_d       = TW'(TIMEOUT - 1);
            end
            S_EXEC: begin
                if (bus.alu_done) begin
                    data_d = bus.alu_result;
                    sreg_d = bus.alu_flags;
                    if (wb_req_q || flag_req_q) begin
                        state_d = S_WB;
                        // A register write aimed at the status register is
                        // dropped when the flag update already covers it.
                        wb_d    = wb_req_q && !(flag_req_q && (rd_q == 3'(SREG_IDX)));
                        fu_d    = flag_req_q;
                        code_d  = rd_q;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end else if (tmr_q == '0) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                cnt_d   = cnt_q + 16'd1;
`ifdef REG_SEQ_BACK2BACK_EN
                accept  = bus.instr_valid && rdy_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d    = S_READ;
            rs1_d      = bus.rs1;
            rs2_d      = bus.rs2;
            rd_d       = bus.rd;
            wb_req_d   = bus.wb_req;
            flag_req_d = bus.flag_req;
            get_en_d   = 1'b1;
            reg1_d     = bus.rs1;
            reg2_d     = bus.rs2;
        end

`ifdef REG_SEQ_BACK2BACK_EN
        rdy_d  = (state_d == S_IDLE) || (state_d == S_WB);
`else
        rdy_d  = (state_d == S_IDLE);
`endif
        busy_d = (state_d != S_IDLE);
    end

    assign bus.instr_ready    = rdy_q;
    assign bus.get_reg_en     = get_en_q;
    assign bus.reg1           = reg1_q;
    assign bus.reg2           = reg2_q;
    assign bus.reg_write_back = wb_q;
    assign bus.reg_write_code = code_q;
    assign bus.data_in        = data_q;
    assign bus.flag_update    = fu_q;
    assign bus.SREG_write     = sreg_q;
    assign bus.alu_start      = alu_start_q;
    assign busy_o             = busy_q;
    assign timeout_err_o      = terr_q;
    assign instr_count_o      = cnt_q;
endmodule

// File: tb/tb_reg_seq_ctrl.sv
module tb_reg_seq_ctrl;
`ifdef REG_SEQ_BACK2BACK_EN
    localparam int B2B = 1;
`else
    localparam int B2B = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy, terr;
    logic [15:0] icnt;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          exp_cnt = 0;

    always #5 clk = ~clk;

    reg_seq_ctrl_if #(.WORD(16)) bus();

    reg_seq_ctrl #(.WORD(16), .SREG_IDX(7), .TIMEOUT(255)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .busy_o        (busy),
        .timeout_err_o (terr),
        .instr_count_o (icnt)
    );

    typedef struct {
        logic [2:0]  rs1, rs2, rd;
        logic        wb, fl;
        logic [15:0] res, flg;
        int          lat;
        logic        e_wb, e_fu, e_wbst;
        logic [2:0]  e_code;
        logic [15:0] e_data, e_sreg;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic [2:0] rs1, rs2, rd, input logic wb, fl,
                                input logic [15:0] res, flg, input int lat,
                                input logic e_wb, e_fu, e_wbst, input logic [2:0] e_code,
                                input logic [15:0] e_data, e_sreg);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wb = wb; v.fl = fl;
        v.res = res; v.flg = flg; v.lat = lat;
        v.e_wb = e_wb; v.e_fu = e_fu; v.e_wbst = e_wbst;
        v.e_code = e_code; v.e_data = e_data; v.e_sreg = e_sreg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_instr(input logic [2:0] rs1, rs2, rd, input logic wb, fl);
        bus.instr_valid = 1'b1;
        bus.rs1 = rs1; bus.rs2 = rs2; bus.rd = rd;
        bus.wb_req = wb; bus.flag_req = fl;
    endtask

    task automatic run_vec(input vec_t v);
        drive_instr(v.rs1, v.rs2, v.rd, v.wb, v.fl);
        tick;
        bus.instr_valid = 1'b0;
        chk("read_en",   32'(bus.get_reg_en), 32'(1));
        chk("read_reg1", 32'(bus.reg1), 32'(v.rs1));
        chk("read_reg2", 32'(bus.reg2), 32'(v.rs2));
        chk("read_rdy",  32'(bus.instr_ready), 32'(0));
        chk("read_busy", 32'(busy), 32'(1));
        tick;
        chk("exec_start", 32'(bus.alu_start), 32'(1));
        chk("exec_en",    32'(bus.get_reg_en), 32'(0));
        for (int k = 0; k < v.lat; k++) begin
            tick;
            if (k == 0) chk("exec_start_pulse", 32'(bus.alu_start), 32'(0));
        end
        bus.alu_done = 1'b1; bus.alu_result = v.res; bus.alu_flags = v.flg;
        tick;
        bus.alu_done = 1'b0;
        chk("wb_write", 32'(bus.reg_write_back), 32'(v.e_wb));
        chk("wb_flag",  32'(bus.flag_update), 32'(v.e_fu));
        chk("wb_busy",  32'(busy), 32'(v.e_wbst));
        if (v.e_wbst) begin
            chk("wb_code", 32'(bus.reg_write_code), 32'(v.e_code));
            chk("wb_data", 32'(bus.data_in), 32'(v.e_data));
            chk("wb_sreg", 32'(bus.SREG_write), 32'(v.e_sreg));
            chk("wb_rdy",  32'(bus.instr_ready), 32'(B2B));
            tick;
        end
        exp_cnt++;
        chk("done_cnt",   32'(icnt), 32'(exp_cnt));
        chk("done_busy",  32'(busy), 32'(0));
        chk("done_rdy",   32'(bus.instr_ready), 32'(1));
        chk("done_write", 32'(bus.reg_write_back), 32'(0));
    endtask

    initial begin
        int n, t1, t2, reads, pend;
        logic saw_wb;

        bus.instr_valid = 1'b0; bus.rs1 = '0; bus.rs2 = '0; bus.rd = '0;
        bus.wb_req = 1'b0; bus.flag_req = 1'b0;
        bus.alu_done = 1'b0; bus.alu_result = '0; bus.alu_flags = '0;

        //            rs1   rs2   rd    wb    fl    res       flg      lat e_wb  e_fu  e_wbst code  data      sreg
        vecs[0] = mk(3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h00AB, 16'h0000, 2, 1'b1, 1'b0, 1'b1, 3'd3, 16'h00AB, 16'h0000);
        vecs[1] = mk(3'd4, 3'd5, 3'd7, 1'b1, 1'b1, 16'h1234, 16'h0003, 1, 1'b0, 1'b1, 1'b1, 3'd7, 16'h1234, 16'h0003);
        vecs[2] = mk(3'd6, 3'd0, 3'd2, 1'b0, 1'b1, 16'h5555, 16'h00F0, 0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h5555, 16'h00F0);
        vecs[3] = mk(3'd7, 3'd7, 3'd0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 3, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000);
        vecs[4] = mk(3'd0, 3'd3, 3'd7, 1'b1, 1'b0, 16'hBEEF, 16'h0001, 0, 1'b1, 1'b0, 1'b1, 3'd7, 16'hBEEF, 16'h0001);
        vecs[5] = mk(3'd2, 3'd1, 3'd5, 1'b1, 1'b1, 16'h0A0A, 16'h8000, 1, 1'b1, 1'b1, 1'b1, 3'd5, 16'h0A0A, 16'h8000);

        // reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_busy",  32'(busy), 32'(0));
        chk("rst_rdy",   32'(bus.instr_ready), 32'(1));
        chk("rst_en",    32'(bus.get_reg_en), 32'(0));
        chk("rst_start", 32'(bus.alu_start), 32'(0));
        chk("rst_write", 32'(bus.reg_write_back), 32'(0));
        chk("rst_flag",  32'(bus.flag_update), 32'(0));
        chk("rst_terr",  32'(terr), 32'(0));
        chk("rst_cnt",   32'(icnt), 32'(0));
        chk("rst_data",  32'(bus.data_in), 32'(0));
        chk("rst_sreg",  32'(bus.SREG_write), 32'(0));
        tick; tick;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // instr_valid held through READ/EXEC with changing fields
        drive_instr(3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
        tick;
        drive_instr(3'd5, 3'd6, 3'd4, 1'b1, 1'b0);
        chk("hold_read_rdy", 32'(bus.instr_ready), 32'(0));
        tick;
        chk("hold_exec_rdy", 32'(bus.instr_ready), 32'(0));
        chk("hold_exec_en",  32'(bus.get_reg_en), 32'(0));
        chk("hold_reg1",     32'(bus.reg1), 32'(1));
        bus.alu_done = 1'b1; bus.alu_result = 16'h0042;
        tick;
        bus.alu_done = 1'b0;
        bus.instr_valid = 1'b0;
        chk("hold_wb_code", 32'(bus.reg_write_code), 32'(3));
        chk("hold_wb_data", 32'(bus.data_in), 32'(16'h0042));
        tick;
        exp_cnt++;
        chk("hold_cnt",  32'(icnt), 32'(exp_cnt));
        chk("hold_busy", 32'(busy), 32'(0));

        // two back-to-back instructions; ALU answers the cycle after alu_start
        drive_instr(3'd1, 3'd1, 3'd1, 1'b1, 1'b0);
        t1 = 0; t2 = 0; reads = 0; pend = 0;
        for (int k = 0; k < 16; k++) begin
            tick;
            bus.alu_done = (pend != 0);
            bus.alu_result = 16'h0011;
            pend = bus.alu_start ? 1 : 0;
            if (bus.get_reg_en) begin
                reads++;
                if (reads == 1) begin
                    t1 = cyc;
                    drive_instr(3'd6, 3'd2, 3'd2, 1'b1, 1'b0);
                end else if (reads == 2) begin
                    t2 = cyc;
                    chk("b2b_reg1", 32'(bus.reg1), 32'(6));
                    bus.instr_valid = 1'b0;
                end
            end
        end
        bus.alu_done = 1'b0;
        chk("b2b_reads",    32'(reads), 32'(2));
        chk("b2b_interval", 32'(t2 - t1), 32'(B2B ? 4 : 5));
        exp_cnt += 2;
        chk("b2b_cnt",  32'(icnt), 32'(exp_cnt));
        chk("b2b_busy", 32'(busy), 32'(0));

        // ALU never answers
        drive_instr(3'd2, 3'd3, 3'd4, 1'b1, 1'b1);
        tick;
        bus.instr_valid = 1'b0;
        tick;
        chk("to_pre_terr", 32'(terr), 32'(0));
        n = 1; saw_wb = 1'b0;
        while (busy === 1'b1 && n < 300) begin
            tick;
            if (busy === 1'b1) n++;
            saw_wb = saw_wb | bus.reg_write_back | bus.flag_update;
        end
        chk("to_cycles", 32'(n), 32'(255));
        chk("to_terr",   32'(terr), 32'(1));
        chk("to_idle",   32'(bus.instr_ready), 32'(1));
        chk("to_cnt",    32'(icnt), 32'(exp_cnt));
        chk("to_nowb",   32'(saw_wb), 32'(0));

        // reset pulsed during EXEC
        drive_instr(3'd1, 3'd2, 3'd1, 1'b1, 1'b0);
        tick;
        bus.instr_valid = 1'b0;
        tick; tick;
        chk("mid_busy_pre", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid_busy",  32'(busy), 32'(0));
        chk("mid_rdy",   32'(bus.instr_ready), 32'(1));
        chk("mid_cnt",   32'(icnt), 32'(0));
        chk("mid_terr",  32'(terr), 32'(0));
        chk("mid_reg1",  32'(bus.reg1), 32'(0));
        chk("mid_data",  32'(bus.data_in), 32'(0));
        tick;
        rst = 1'b0;
        bus.alu_done = 1'b1; bus.alu_result = 16'h7777;
        saw_wb = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            saw_wb = saw_wb | bus.reg_write_back;
        end
        bus.alu_done = 1'b0;
        chk("mid_nowb",      32'(saw_wb), 32'(0));
        chk("mid_post_busy", 32'(busy), 32'(0));
        chk("mid_post_cnt",  32'(icnt), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_seq_ctrl.md
REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

Interface
REQ-001 SHALL have parameter WORD, default 16, meaning data/status width (matches `WORD).
REQ-002 SHALL have parameter SREG_IDX, default 7, meaning register index of the status register (matches `SREG).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of EXEC cycles waiting for alu_done.
REQ-004 SHALL have port clk  in  1  system clock; all state changes on posedge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have instruction-side ports:
- instr_valid in 1, instr_ready out 1: valid/ready handshake.
- rs1, rs2, rd in 3: source/destination codes.
- wb_req in 1: instruction writes rd.
- flag_req in 1: instruction updates SREG.
REQ-007 SHALL have register-file control ports:
- get_reg_en out 1; reg1, reg2 out 3.
- reg_write_back out 1; reg_write_code out 3; data_in out WORD.
- flag_update out 1; SREG_write out WORD.
REQ-008 SHALL have ALU ports:
- alu_start out 1.
- alu_done in 1.
- alu_result in WORD.
- alu_flags in WORD.
REQ-009 SHALL have status ports:
- busy out 1.
- timeout_err out 1 (sticky).
- instr_count out 16.

Function
REQ-010 SHALL implement FSM IDLE -> READ -> EXEC -> WB -> IDLE; all outputs registered.
REQ-011 SHALL in IDLE:
- assert instr_ready=1.
- On instr_valid&instr_ready, latch rs1/rs2/rd/wb_req/flag_req and go to READ.
REQ-012 SHALL in READ assert get_reg_en=1 for exactly one cycle with reg1=rs1_l and reg2=rs2_l, then go to EXEC.
REQ-013 SHALL pulse alu_start for exactly the first EXEC cycle.
REQ-014 SHALL wait in EXEC for alu_done; on alu_done latch alu_result/alu_flags, then:
- go to WB if wb_req_l|flag_req_l;
- else go to IDLE.
REQ-015 SHALL count EXEC cycles; if TIMEOUT cycles elapse without alu_done, set timeout_err=1 and return to IDLE with no register write.
REQ-016 SHALL hold WB for one cycle, asserting:
- reg_write_back=wb_req_l, reg_write_code=rd_l, data_in=result_l;
- flag_update=flag_req_l, SREG_write=flags_l.
REQ-017 SHALL, when wb_req_l=1, flag_req_l=1 and rd_l=SREG_IDX, suppress reg_write_back and assert flag_update only.
REQ-018 SHALL increment instr_count (wrapping 0xFFFF->0) once per completed instruction (WB exit, or EXEC exit with no write); timeouts are not counted.
REQ-019 SHALL drive busy=1 in every state except IDLE.
REQ-020 SHALL keep instr_ready=0 outside IDLE; instr_valid there is ignored and no fields are latched.
REQ-021 SHALL ignore alu_done outside EXEC.

Reset
REQ-022 SHALL on rst=1, immediately and independent of clk:
- go to IDLE;
- clear every 1-bit output except instr_ready (instr_ready=1);
- clear reg1/reg2/reg_write_code/data_in/SREG_write to 0;
- clear instr_count, timeout_err and the timeout counter.
REQ-023 SHALL, on reset mid-instruction, abandon it with no write-back and not count it.

Configuration
REQ-024 SHALL, with macro REG_SEQ_BACK2BACK_EN defined, also assert instr_ready in WB; a handshake in WB latches the new fields and goes directly to READ.
REQ-025 SHALL, with REG_SEQ_BACK2BACK_EN undefined, keep instr_ready=0 in WB; every instruction passes through IDLE (minimum 4 cycles per instruction).

Verification
REQ-026 SHALL cover: instr rs1=1, rs2=2, rd=3, wb_req=1; alu_done 2 cycles after alu_start with result 0x00AB -> get_reg_en one cycle with reg1=1/reg2=2; WB cycle with reg_write_back=1, code=3, data_in=0x00AB; instr_count=1.
REQ-027 SHALL cover: wb_req=1, flag_req=1, rd=7, flags 0x0003 -> flag_update=1, SREG_write=0x0003, reg_write_back=0.
REQ-028 SHALL cover: alu_done never asserted -> timeout_err=1 after 255 EXEC cycles, FSM back in IDLE, instr_count unchanged.
REQ-029 SHALL cover: rst pulsed during EXEC -> outputs at reset values the same cycle, no write-back after release.
REQ-030 SHALL cover: two back-to-back valid instructions -> issue interval 4 cycles with REG_SEQ_BACK2BACK_EN defined, 5 cycles without.
REQ-031 SHALL cover: instr_valid high during READ/EXEC -> not accepted; instruction taken only when instr_ready=1.
